// File: rtl/piano_voice_allocator.sv
// Round-robin voice allocator: binds pressed piano keys to NUM_VOICES shared voices.
// Optional macro PIANO_VOICE_STEAL_EN: when all voices are busy, a new key steals the oldest voice.
module piano_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              key_req,
    output logic [NUM_VOICES-1:0]   voice_en,
    output logic [3*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_load,
    output logic [7:0]              key_granted,
    output logic                    busy
);

    logic [2:0]       scan_ptr;
    logic [AGE_W-1:0] age [NUM_VOICES];

    logic                    cur_req;
    logic                    cur_gnt;
    logic [NUM_VOICES-1:0]   free_oh;
    logic [NUM_VOICES-1:0]   owner_oh;
    logic [NUM_VOICES-1:0]   en_n;
    logic [3*NUM_VOICES-1:0] note_n;
    logic [NUM_VOICES-1:0]   load_n;
    logic [7:0]              gnt_n;
`ifdef PIANO_VOICE_STEAL_EN
    logic [NUM_VOICES-1:0]   victim_oh;
    logic [AGE_W-1:0]        best_age;
`endif

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    always_comb begin
        cur_req  = key_req[scan_ptr];
        cur_gnt  = key_granted[scan_ptr];
        free_oh  = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!voice_en[i] && free_oh == '0)
                free_oh[i] = 1'b1;
            if (voice_en[i] && voice_note[3*i +: 3] == scan_ptr)
                owner_oh[i] = 1'b1;
        end
`ifdef PIANO_VOICE_STEAL_EN
        // Strict '>' keeps the lowest index on equal ages.
        victim_oh = '0;
        best_age  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (victim_oh == '0 || age[i] > best_age) begin
                victim_oh    = '0;
                victim_oh[i] = 1'b1;
                best_age     = age[i];
            end
        end
`endif
    end

    always_comb begin
        en_n   = voice_en;
        note_n = voice_note;
        load_n = '0;
        gnt_n  = key_granted;
        if (!cur_req && cur_gnt) begin
            gnt_n[scan_ptr] = 1'b0;
            for (int i = 0; i < NUM_VOICES; i++)
                if (owner_oh[i])
                    en_n[i] = 1'b0;
        end else if (cur_req && !cur_gnt) begin
            if (free_oh != '0) begin
                gnt_n[scan_ptr] = 1'b1;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (free_oh[i]) begin
                        en_n[i]           = 1'b1;
                        note_n[3*i +: 3]  = scan_ptr;
                        load_n[i]         = 1'b1;
                    end
                end
            end else begin
`ifdef PIANO_VOICE_STEAL_EN
                // Victim's old key loses its grant before the new key claims it.
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (victim_oh[i]) begin
                        gnt_n[voice_note[3*i +: 3]] = 1'b0;
                        note_n[3*i +: 3]            = scan_ptr;
                        load_n[i]                   = 1'b1;
                    end
                end
                gnt_n[scan_ptr] = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_ptr    <= '0;
            voice_en    <= '0;
            voice_note  <= '0;
            voice_load  <= '0;
            key_granted <= '0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++)
                age[i] <= '0;
        end else begin
            scan_ptr    <= scan_ptr + 3'd1;
            voice_en    <= en_n;
            voice_note  <= note_n;
            voice_load  <= load_n;
            key_granted <= gnt_n;
            busy        <= &en_n;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load_n[i])
                    age[i] <= '0;
                else if (en_n[i])
                    age[i] <= age_inc(age[i]);
                else
                    age[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_piano_voice_allocator.sv
// Directed + randomized bench for piano_voice_allocator against an array-based key/voice model.
// Honors PIANO_VOICE_STEAL_EN the same way as the design build.
module tb_piano_voice_allocator;
    localparam int NV   = 4;
    localparam int AMAX = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    key_req = '0;
    logic [NV-1:0] voice_en;
    logic [3*NV-1:0] voice_note;
    logic [NV-1:0] voice_load;
    logic [7:0]    key_granted;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference state: which key each voice plays, how long, and which keys hold a voice.
    int m_ptr;
    bit m_en [NV];
    int m_note [NV];
    int m_age [NV];
    bit m_load [NV];
    bit m_gnt [8];

    piano_voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk(clk), .reset(reset), .key_req(key_req), .voice_en(voice_en),
        .voice_note(voice_note), .voice_load(voice_load),
        .key_granted(key_granted), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int k, v;
        for (int i = 0; i < NV; i++) m_load[i] = 0;
        if (reset) begin
            m_ptr = 0;
            for (int i = 0; i < NV; i++) begin m_en[i] = 0; m_note[i] = 0; m_age[i] = 0; end
            for (int i = 0; i < 8; i++) m_gnt[i] = 0;
            return;
        end
        k = m_ptr;
        if (key_req[k] && !m_gnt[k]) begin
            v = -1;
            for (int i = NV-1; i >= 0; i--) if (!m_en[i]) v = i;
`ifdef PIANO_VOICE_STEAL_EN
            if (v < 0) begin
                v = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[v]) v = i;
                m_gnt[m_note[v]] = 0;
            end
`endif
            if (v >= 0) begin
                m_en[v] = 1; m_note[v] = k; m_load[v] = 1; m_gnt[k] = 1;
            end
        end else if (!key_req[k] && m_gnt[k]) begin
            m_gnt[k] = 0;
            for (int i = 0; i < NV; i++) if (m_en[i] && m_note[i] == k) m_en[i] = 0;
        end
        for (int i = 0; i < NV; i++) begin
            if (m_load[i]) m_age[i] = 0;
            else if (m_en[i]) m_age[i] = (m_age[i] < AMAX) ? m_age[i] + 1 : AMAX;
            else m_age[i] = 0;
        end
        m_ptr = (m_ptr + 1) % 8;
    endtask

    task automatic check_all();
        logic [NV-1:0] e_en, e_ld;
        logic [3*NV-1:0] e_note;
        logic [7:0] e_gnt;
        int owners;
        bit en_ok;
        e_gnt = '0;
        for (int i = 0; i < NV; i++) begin
            e_en[i] = m_en[i];
            e_ld[i] = m_load[i];
            e_note[3*i +: 3] = 3'(m_note[i]);
        end
        for (int i = 0; i < 8; i++) e_gnt[i] = m_gnt[i];
        chk("voice_en", 32'(voice_en), 32'(e_en));
        chk("voice_note", 32'(voice_note), 32'(e_note));
        chk("voice_load", 32'(voice_load), 32'(e_ld));
        chk("key_granted", 32'(key_granted), 32'(e_gnt));
        chk("busy", 32'(busy), 32'(&e_en));
        chk("load_onehot0", 32'($onehot0(voice_load)), 32'd1);
        en_ok = 1;
        for (int k = 0; k < 8; k++) begin
            owners = 0;
            for (int i = 0; i < NV; i++)
                if (voice_en[i] && voice_note[3*i +: 3] == 3'(k)) owners++;
            if (owners > 1) en_ok = 0;
        end
        for (int i = 0; i < NV; i++)
            if (voice_en[i] && !key_granted[voice_note[3*i +: 3]]) en_ok = 0;
        chk("exclusivity", 32'(en_ok), 32'd1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1;
        repeat (cycles) tick();
        chk("reset_en", 32'(voice_en), 32'd0);
        chk("reset_gnt", 32'(key_granted), 32'd0);
        reset = 0;
    endtask

    initial begin
        int loads;
        bit seen;

        // Reset with all keys down, then key0 grabs voice0 on the first cycle.
        key_req = 8'hFF;
        do_reset(2);
        tick();
        chk("t1_first_en", 32'(voice_en), 32'h1);
        chk("t1_first_load", 32'(voice_load), 32'h1);
        chk("t1_first_gnt", 32'(key_granted), 32'h01);
        repeat (7) tick();

        // Two keys from idle.
        key_req = 8'h00;
        do_reset(1);
        key_req = 8'b0000_0101;
        loads = 0;
        repeat (8) begin tick(); if (voice_load != 0) loads++; end
        chk("t2_loads", 32'(loads), 32'd2);
        chk("t2_gnt", 32'(key_granted), 32'h05);
        chk("t2_note0", 32'(voice_note[2:0]), 32'd0);
        chk("t2_note1", 32'(voice_note[5:3]), 32'd2);

        // Release key3, then key6 reuses voice3.
        key_req = 8'h00;
        do_reset(1);
        key_req = 8'h0F;
        repeat (8) tick();
        chk("t3_busy", 32'(busy), 32'd1);
        key_req = 8'h07;
        repeat (8) tick();
        chk("t3_rel_en", 32'(voice_en), 32'h7);
        chk("t3_rel_note_kept", 32'(voice_note[11:9]), 32'd3);
        key_req = 8'h47;
        repeat (8) tick();
        chk("t3_note6", 32'(voice_note[11:9]), 32'd6);
        chk("t3_en", 32'(voice_en), 32'hF);

`ifndef PIANO_VOICE_STEAL_EN
        // Keys 0-4: key4 never served.
        key_req = 8'h00;
        do_reset(1);
        key_req = 8'h1F;
        loads = 0;
        repeat (8) begin tick(); if (voice_load != 0) loads++; end
        chk("t4_initial_loads", 32'(loads), 32'd4);
        loads = 0;
        repeat (24) begin tick(); if (voice_load != 0) loads++; end
        chk("t4_no_more_loads", 32'(loads), 32'd0);
        chk("t4_key4", 32'(key_granted[4]), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
`else
        // Saturated ages: key5 steals voice0.
        key_req = 8'h00;
        do_reset(1);
        key_req = 8'h0F;
        repeat (300) tick();
        key_req = 8'h2F;
        seen = 0;
        for (int n = 0; n < 16 && !seen; n++) begin
            tick();
            if (voice_load != 0) seen = 1;
        end
        chk("t5_steal_seen", 32'(seen), 32'd1);
        chk("t5_load", 32'(voice_load), 32'h1);
        chk("t5_note", 32'(voice_note[2:0]), 32'd5);
        chk("t5_gnt0", 32'(key_granted[0]), 32'd0);
        chk("t5_en0", 32'(voice_en[0]), 32'd1);
        repeat (20) tick();
`endif

        // Reset mid-allocation, then scan restarts at key0.
        key_req = 8'hA5;
        repeat (5) tick();
        do_reset(1);
        chk("t6_load", 32'(voice_load), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        key_req = 8'h01;
        tick();
        chk("t6_restart", 32'(voice_load), 32'h1);

        // Random key activity with occasional resets.
        for (int blk = 0; blk < 150; blk++) begin
            key_req = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                reset = 1;
                tick();
                reset = 0;
            end
            repeat ($urandom_range(3, 20)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
